// File: rtl/online_pkg.sv
// Shared definitions for the online arithmetic output stage: signed-digit
// encodings, converter state names and the default word length.
package online_pkg;

    localparam int DEFAULT_DIGITS = 16;

    // Signed-digit codes on {d_plus, d_minus}; 2'b11 also decodes to zero.
    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_ZERO = 2'b00;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } otf_state_e;

endpackage

// File: rtl/otf_select_cell.sv
// One on-the-fly conversion step: selects the next Q / QM pair for a single
// signed digit. Pure muxing of shifted registers; no carry chain. Kept as a
// separate cell so several can be chained for multi-digit-per-beat variants.
module otf_select_cell
    import online_pkg::*;
#(
    parameter int W = DEFAULT_DIGITS + 1
) (
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] qm_i,
    input  logic         d_plus_i,
    input  logic         d_minus_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] qm_o
);

    // Shift left by one and append a new LSB; the MSB falls off the top.
    function automatic logic [W-1:0] shl(input logic [W-1:0] v, input logic b);
        return W'({v, b});
    endfunction

    // Digit-driven selection keeping the invariant qm_o == q_o - 1.
    always_comb begin
        q_o  = shl(q_i, 1'b0);
        qm_o = shl(qm_i, 1'b1);
        case ({d_plus_i, d_minus_i})
            SD_POS: begin
                q_o  = shl(q_i, 1'b1);
                qm_o = shl(q_i, 1'b0);
            end
            SD_NEG: begin
                q_o  = shl(qm_i, 1'b1);
                qm_o = shl(qm_i, 1'b0);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/otf_sd_converter.sv
// Serial signed-digit to two's complement converter. Accepts one digit per
// beat MSB first, keeps Q and QM = Q-1 so every digit resolves by selection,
// and presents the finished word under a valid/ready output handshake.
//
// Handshakes: a digit transfers on a cycle where in_valid && in_ready; a
// result transfers on a cycle where out_valid && out_ready. in_ready and
// out_valid depend only on the state register, never on the inputs.
module otf_sd_converter
    import online_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int CW     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          d_plus,
    input  logic          d_minus,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DIGITS:0] result,
    output logic          result_zero,
    output logic          dbg_state
);

    localparam int W = DIGITS + 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    otf_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  qm_q, qm_d;
    logic [W-1:0]  res_q, res_d;
    logic          zero_q, zero_d;
    logic [W-1:0]  q_sel, qm_sel;
    logic          accept;

    otf_select_cell #(.W(W)) u_cell (
        .q_i       (q_q),
        .qm_i      (qm_q),
        .d_plus_i  (d_plus),
        .d_minus_i (d_minus),
        .q_o       (q_sel),
        .qm_o      (qm_sel)
    );

    assign in_ready    = (state_q == ACCUM);
    assign out_valid   = (state_q == DONE);
    assign accept      = in_valid && in_ready;
    assign result      = res_q;
    assign result_zero = zero_q;
    assign dbg_state   = state_q;

    // Next-state: flush wins, otherwise accumulate digits or wait for the consumer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        q_d     = q_q;
        qm_d    = qm_q;
        res_d   = res_q;
        zero_d  = zero_q;
        if (flush) begin
            state_d = ACCUM;
            count_d = '0;
            q_d     = '0;
            qm_d    = '1;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        q_d  = q_sel;
                        qm_d = qm_sel;
                        if (count_q == LAST) begin
                            count_d = '0;
                            state_d = DONE;
                            res_d   = q_sel;
                            zero_d  = (q_sel == '0);
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        q_d     = '0;
                        qm_d    = '1;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            count_q <= '0;
            q_q     <= '0;
            qm_q    <= '1;
            res_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

endmodule
